// File: rtl/gpu_pkg.sv
// Shared types for the GPU write scheduler: FSM state encoding and the
// queued write entry. Entry fields are sized for the widest supported
// address/data; narrower instances zero-extend on the way in.
package gpu_pkg;

  localparam int ENTRY_ADDR_WIDTH = 24;
  localparam int ENTRY_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    S_WAIT_BLANK = 2'd0,
    S_DRAIN      = 2'd1,
    S_HOLD       = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [ENTRY_ADDR_WIDTH-1:0] addr;
    logic [ENTRY_DATA_WIDTH-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data, synchronous
// clear and an occupancy count. DEPTH must be a power of two.
module sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 56,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_write_scheduler.sv
// Queues cluster writes and releases them only during vertical blanking,
// at most BUDGET per blank. Optional stall statistic enabled by defining
// GPU_SCHED_STATS_EN. ADDR_WIDTH/DATA_WIDTH must not exceed the entry
// field widths in gpu_pkg.
//
//   state        | meaning
//   WAIT_BLANK   | idle, waiting for a vblank rising edge
//   DRAIN        | popping one queued write per cycle
//   HOLD         | budget spent, waiting for vblank to fall
module gpu_write_scheduler
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int BUDGET     = 512,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int BW = $clog2(BUDGET + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  vblank,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_wen,
  output logic [CW-1:0]         pending,
  output logic                  frame_done,
  output logic [15:0]           stall_count
);

  sched_state_t  state;
  logic          vblank_q;
  logic [BW-1:0] budget;
  wr_entry_t     push_entry;
  wr_entry_t     head_entry;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign push_entry = '{addr: ENTRY_ADDR_WIDTH'(in_addr), data: ENTRY_DATA_WIDTH'(in_data)};
  assign in_ready   = !full;
  assign push       = in_valid && in_ready && !flush;
  assign pop        = (state == S_DRAIN) && vblank && !empty && !flush;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wr_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  // Blank-gated drain sequencer with registered write port and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT_BLANK;
      vblank_q   <= 1'b1;
      budget     <= '0;
      out_wen    <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      vblank_q   <= vblank;
      out_wen    <= pop;
      frame_done <= 1'b0;
      if (pop) begin
        out_addr <= ADDR_WIDTH'(head_entry.addr);
        out_data <= DATA_WIDTH'(head_entry.data);
      end
      if (flush) begin
        state  <= S_WAIT_BLANK;
        budget <= '0;
      end else begin
        case (state)
          S_WAIT_BLANK: begin
            if (vblank && !vblank_q) begin
              state  <= S_DRAIN;
              budget <= '0;
            end
          end
          S_DRAIN: begin
            if (!vblank) begin
              state <= S_WAIT_BLANK;
            end else if (empty) begin
              // An entry arriving into an empty queue keeps the blank open.
              if (!push) begin
                state      <= S_WAIT_BLANK;
                frame_done <= 1'b1;
              end
            end else begin
              budget <= budget + 1'b1;
              if (budget == BW'(BUDGET - 1)) state <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (!vblank) state <= S_WAIT_BLANK;
          end
          default: state <= S_WAIT_BLANK;
        endcase
      end
    end
  end

`ifdef GPU_SCHED_STATS_EN
  // Saturating count of cycles a requester was held off by a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_gpu_write_scheduler.sv
// Scoreboard bench for gpu_write_scheduler: a queue-based reference model
// predicts each cycle's pops, a negedge monitor compares DUT outputs.
module tb_gpu_write_scheduler;

  localparam int AW     = 24;
  localparam int DW     = 32;
  localparam int DEPTH  = 8;
  localparam int BUDGET = 5;
  localparam int PW     = $clog2(DEPTH) + 1;
`ifdef GPU_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          vblank;
  logic          flush;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_wen;
  logic [PW-1:0] pending;
  logic          frame_done;
  logic [15:0]   stall_count;

  always #5 clk = ~clk;

  gpu_write_scheduler #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .BUDGET     (BUDGET)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .vblank      (vblank),
    .flush       (flush),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_wen     (out_wen),
    .pending     (pending),
    .frame_done  (frame_done),
    .stall_count (stall_count)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];
  ent_t exp_q[$];
  int   m_mode   = 0;   // 0 waiting for blank, 1 draining, 2 budget spent
  int   m_budget = 0;
  bit   m_vq     = 1'b1;
  bit   m_fd     = 1'b0;
  bit   m_wen    = 1'b0;
  int   m_stall  = 0;
  int   wen_seen = 0;
  int   fd_seen  = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: one step per clock using the queue occupancy rules.
  always @(posedge clk) begin : model
    bit acc;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_mode = 0; m_budget = 0; m_vq = 1'b1;
      m_fd = 1'b0; m_wen = 1'b0; m_stall = 0;
    end else begin
      acc = in_valid && (mq.size() != DEPTH);
      if (STATS && in_valid && (mq.size() == DEPTH) && (m_stall < 65535)) m_stall++;
      m_fd  = 1'b0;
      m_wen = 1'b0;
      if (flush) begin
        mq.delete();
        m_mode = 0;
        m_budget = 0;
      end else begin
        case (m_mode)
          0: if (vblank && !m_vq) begin m_mode = 1; m_budget = 0; end
          1: begin
            if (!vblank) m_mode = 0;
            else if (mq.size() == 0) begin
              if (!acc) begin m_mode = 0; m_fd = 1'b1; end
            end else begin
              exp_q.push_back(mq.pop_front());
              m_wen = 1'b1;
              m_budget++;
              if (m_budget == BUDGET) m_mode = 2;
            end
          end
          default: if (!vblank) m_mode = 0;
        endcase
        if (acc) mq.push_back('{in_addr, in_data});
      end
      m_vq = vblank;
    end
  end

  // Monitor: compare every observable output against the model mid-cycle.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (!rst) begin
      chk("pending", pending, mq.size());
      chk("in_ready", in_ready, (mq.size() != DEPTH));
      chk("frame_done", frame_done, m_fd);
      chk("stall_count", stall_count, m_stall);
      chk("out_wen", out_wen, m_wen);
      if (frame_done) fd_seen++;
      if (out_wen) begin
        wen_seen++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: got write %0h/%0h expected none", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_addr", out_addr, e.a);
          chk("out_data", out_data, e.d);
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic blank(input int n);
    vblank = 1'b1;
    repeat (n) @(negedge clk);
    vblank = 1'b0;
  endtask

  initial begin : stim
    int w0, f0, run;
    rst = 1'b1; vblank = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_pending", pending, 0);
    chk("reset_wen", out_wen, 0);

    // Released mid-blank: queued writes wait for a fresh rising edge.
    w0 = wen_seen; f0 = fd_seen;
    push_one(24'h100, $urandom);
    push_one(24'h104, $urandom);
    vblank = 1'b1;
    idle(5);
    chk("midblank_no_wen", wen_seen - w0, 0);
    vblank = 1'b0;
    idle(2);
    blank(6);
    chk("midblank_drain_wen", wen_seen - w0, 2);
    chk("midblank_fd", fd_seen - f0, 1);
    idle(2);

    // Three writes wait for blank, then drain in order with a done pulse.
    w0 = wen_seen; f0 = fd_seen;
    push_one(24'h10, 32'hA);
    push_one(24'h14, 32'hB);
    push_one(24'h18, 32'hC);
    idle(3);
    chk("noblank_no_wen", wen_seen - w0, 0);
    blank(10);
    chk("three_wen", wen_seen - w0, 3);
    chk("three_fd", fd_seen - f0, 1);
    chk("three_pending", pending, 0);
    idle(2);

    // Back-to-back requests into a full queue.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_addr = AW'($urandom); in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_pending", pending, DEPTH);
    chk("full_ready", in_ready, 0);
    chk("full_stalls", stall_count, STATS ? 2 : 0);

    // Budget caps a long blank; the next blank finishes the queue.
    w0 = wen_seen; f0 = fd_seen;
    blank(20);
    chk("budget_wen", wen_seen - w0, BUDGET);
    chk("budget_pending", pending, DEPTH - BUDGET);
    chk("budget_no_fd", fd_seen - f0, 0);
    idle(2);
    blank(10);
    chk("budget2_wen", wen_seen - w0, DEPTH);
    chk("budget2_fd", fd_seen - f0, 1);
    idle(2);

    // Blank ends after a single pop.
    for (int i = 0; i < 4; i++) push_one(AW'($urandom), $urandom);
    w0 = wen_seen; f0 = fd_seen;
    blank(2);
    idle(3);
    chk("short_wen", wen_seen - w0, 1);
    chk("short_pending", pending, 3);
    chk("short_fd", fd_seen - f0, 0);

    // Flush in the middle of a drain.
    for (int i = 0; i < 3; i++) push_one(AW'($urandom), $urandom);
    w0 = wen_seen;
    vblank = 1'b1;
    idle(2);
    chk("preflush_pending", pending, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_pending", pending, 0);
    idle(5);
    vblank = 1'b0;
    chk("flush_wen", wen_seen - w0, 1);
    idle(2);

    // Randomized traffic with long vblank runs and occasional flushes.
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        vblank = ~vblank;
        run = int'($urandom_range(30, 1));
      end
      run--;
      in_valid = ($urandom_range(2, 0) != 0);
      in_addr  = AW'($urandom);
      in_data  = $urandom;
      flush    = ($urandom_range(99, 0) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; vblank = 1'b0;
    idle(4);
    chk("leftover_expected", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_write_scheduler.md
GPU_WRITE_SCHEDULER -- requirements
Module: gpu_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, write address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-003 SHALL have parameter DEPTH, default 64, FIFO entries; power of 2, >= 2.
REQ-004 SHALL have parameter BUDGET, default 512, maximum writes issued per blanking interval; >= 1.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic in this domain.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port in_addr, input, ADDR_WIDTH, requested write address.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, requested write data.
REQ-009 SHALL have port in_valid, input, 1, write request present.
REQ-010 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-011 SHALL have port vblank, input, 1, level, high during vertical blanking, synchronous to clk.
REQ-012 SHALL have port flush, input, 1, discard all queued writes.
REQ-013 SHALL have port out_addr, output, ADDR_WIDTH, address to cluster write port.
REQ-014 SHALL have port out_data, output, DATA_WIDTH, data to cluster write port.
REQ-015 SHALL have port out_wen, output, 1, one-cycle write strobe.
REQ-016 SHALL have port pending, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse when the queue fully drains during a blank.
REQ-018 SHALL have port stall_count, output, 16, stall statistic (see Configuration).

Function
REQ-019 SHALL queue accepted requests in FIFO order; in_ready = (pending != DEPTH), combinational; a push is refused when full even if a pop occurs the same cycle.
REQ-020 SHALL implement states WAIT_BLANK, DRAIN, HOLD.
REQ-021 WAIT_BLANK -> DRAIN on vblank rising edge (vblank=1, registered vblank_q=0); budget counter cleared on entry.
REQ-022 DRAIN: each cycle with FIFO non-empty SHALL pop one entry; out_addr/out_data/out_wen registered, valid the cycle after the pop (latency 1).
REQ-023 DRAIN -> WAIT_BLANK when FIFO empty (frame_done pulses 1 cycle, registered) or when vblank=0 (no pop that cycle, no frame_done).
REQ-024 DRAIN -> HOLD when budget reaches BUDGET writes; HOLD -> WAIT_BLANK when vblank=0.
REQ-025 No pop SHALL occur outside DRAIN; out_wen SHALL be 0 except the cycle after a pop.
REQ-026 Entry pushed in cycle N SHALL be poppable from cycle N+1; push to empty FIFO during DRAIN is drained in the same blank.
REQ-027 pending SHALL update: +1 push, -1 pop, unchanged for both or neither.
REQ-028 flush SHALL clear FIFO and budget in one cycle, force state WAIT_BLANK, suppress push and pop that cycle; out_wen from a pop in the prior cycle still completes.

Reset
REQ-029 On rst: state WAIT_BLANK, FIFO empty, pending 0, out_wen 0, out_addr 0, out_data 0, frame_done 0, stall_count 0, budget 0.
REQ-030 vblank_q SHALL reset to 1 so a blank in progress at reset release never triggers draining.

Configuration
REQ-031 Macro GPU_SCHED_STATS_EN: defined -> stall_count counts cycles with in_valid && !in_ready, saturating at 16'hFFFF, cleared only by rst; undefined -> stall_count tied to 0, no counter logic.

Structure
REQ-032 Package gpu_pkg SHALL hold typedef sched_state_t (enum) and typedef for the addr/data FIFO entry struct.
REQ-033 FIFO SHALL be sub-module sync_fifo (DEPTH, WIDTH parameters, push/pop/full/empty/count).

Verification
REQ-034 Push 3 writes (0x10/0xA,0x14/0xB,0x18/0xC) with vblank=0 -> no out_wen; raise vblank -> out_wen on 3 consecutive cycles in order, then frame_done pulse, pending=0.
REQ-035 DEPTH=4: 6 back-to-back requests -> in_ready=0 after 4th, pending=4; with STATS_EN, stall_count=2 after 2 stall cycles.
REQ-036 BUDGET=2, 5 queued, vblank high 20 cycles -> exactly 2 out_wen, state HOLD, pending=3; next blank drains 2 more.
REQ-037 vblank drops after 1 pop of 4 queued -> 1 out_wen, pending=3, no frame_done.
REQ-038 rst released while vblank=1 with queue empty, then 2 pushes -> no out_wen until vblank falls and rises again.
REQ-039 flush with pending=5 during DRAIN -> pending=0 next cycle, state WAIT_BLANK, no further out_wen.
